// File: rtl/loader_pkg.sv
// Shared types and constants for matrix_loader: FSM states, frame geometry and the
// byte-index-to-port mapping. LOADER_CHECKSUM_EN adds the CHECK state and a 26th byte.
package loader_pkg;

    localparam int unsigned NUM_INPUT  = 16;
    localparam int unsigned NUM_FILTER = 9;
    localparam int unsigned FRAME_LEN  = NUM_INPUT + NUM_FILTER;

    // Row-major placement: a-matrix 4x4 from byte 0, b-matrix 3x3 from byte 16.
    localparam int unsigned A_BASE = 0;
    localparam int unsigned A_COLS = 4;
    localparam int unsigned B_BASE = NUM_INPUT;
    localparam int unsigned B_COLS = 3;

`ifdef LOADER_CHECKSUM_EN
    localparam int unsigned LAST_IDX = FRAME_LEN;
    typedef enum logic [1:0] {
        StLoad     = 2'd0,
        StCheck    = 2'd1,
        StIssue    = 2'd2,
        StWaitDone = 2'd3
    } state_e;
`else
    localparam int unsigned LAST_IDX = FRAME_LEN - 1;
    typedef enum logic [1:0] {
        StLoad     = 2'd0,
        StIssue    = 2'd2,
        StWaitDone = 2'd3
    } state_e;
`endif

    // Row and column are 1-based to match the port names.
    function automatic int unsigned a_idx(input int unsigned row, input int unsigned col);
        return A_BASE + (row - 1) * A_COLS + (col - 1);
    endfunction

    function automatic int unsigned b_idx(input int unsigned row, input int unsigned col);
        return B_BASE + (row - 1) * B_COLS + (col - 1);
    endfunction

endpackage

// File: rtl/matrix_loader.sv
// Streams a 4x4 input matrix and 3x3 filter into registers, strobes a capture and waits
// for its acknowledge with a timeout. Define LOADER_CHECKSUM_EN for a trailing checksum byte.
module matrix_loader
    import loader_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [7:0] a11_o, a12_o, a13_o, a14_o,
    output logic [7:0] a21_o, a22_o, a23_o, a24_o,
    output logic [7:0] a31_o, a32_o, a33_o, a34_o,
    output logic [7:0] a41_o, a42_o, a43_o, a44_o,
    output logic [7:0] b11_o, b12_o, b13_o,
    output logic [7:0] b21_o, b22_o, b23_o,
    output logic [7:0] b31_o, b32_o, b33_o,
    output logic       run_valid_o,
    input  logic       done_capture_i,
    output logic       busy_o,
    output logic       err_o
);

    state_e      state_q, state_d;
    logic [4:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [7:0]  mem_q [FRAME_LEN];
    logic        accept, last_byte, store_byte, timeout_hit;

    assign ready_o     = (state_q == StLoad);
    assign busy_o      = ~ready_o;
    assign accept      = valid_i & ready_o;
    assign last_byte   = accept & (byte_cnt_q == 5'(LAST_IDX));
    assign store_byte  = accept & (byte_cnt_q < 5'(FRAME_LEN));
    assign timeout_hit = (wait_cnt_q == 16'(WAIT_TIMEOUT - 1));

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q, chk_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
            chk_q <= '0;
        end else begin
            if (state_q == StCheck) begin
                sum_q <= '0;
            end else if (store_byte) begin
                sum_q <= sum_q + data_i;
            end
            if (last_byte) begin
                chk_q <= data_i;
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        run_valid_o = 1'b0;
        err_o       = 1'b0;
        byte_cnt_d  = byte_cnt_q;
        wait_cnt_d  = (state_q == StWaitDone) ? wait_cnt_q + 16'd1 : 16'd0;
        if (accept) begin
            byte_cnt_d = last_byte ? 5'd0 : byte_cnt_q + 5'd1;
        end
        unique case (state_q)
            StLoad: begin
                if (last_byte) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = StCheck;
`else
                    state_d = StIssue;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                if (sum_q == chk_q) begin
                    state_d = StIssue;
                end else begin
                    err_o   = 1'b1;
                    state_d = StLoad;
                end
            end
`endif
            StIssue: begin
                run_valid_o = 1'b1;
                state_d     = StWaitDone;
            end
            StWaitDone: begin
                // Acknowledge takes priority over a coincident timeout.
                if (done_capture_i) begin
                    state_d = StLoad;
                end else if (timeout_hit) begin
                    err_o   = 1'b1;
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StLoad;
            byte_cnt_q <= '0;
            wait_cnt_q <= '0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            if (store_byte) begin
                mem_q[byte_cnt_q] <= data_i;
            end
        end
    end

    assign a11_o = mem_q[a_idx(1, 1)];
    assign a12_o = mem_q[a_idx(1, 2)];
    assign a13_o = mem_q[a_idx(1, 3)];
    assign a14_o = mem_q[a_idx(1, 4)];
    assign a21_o = mem_q[a_idx(2, 1)];
    assign a22_o = mem_q[a_idx(2, 2)];
    assign a23_o = mem_q[a_idx(2, 3)];
    assign a24_o = mem_q[a_idx(2, 4)];
    assign a31_o = mem_q[a_idx(3, 1)];
    assign a32_o = mem_q[a_idx(3, 2)];
    assign a33_o = mem_q[a_idx(3, 3)];
    assign a34_o = mem_q[a_idx(3, 4)];
    assign a41_o = mem_q[a_idx(4, 1)];
    assign a42_o = mem_q[a_idx(4, 2)];
    assign a43_o = mem_q[a_idx(4, 3)];
    assign a44_o = mem_q[a_idx(4, 4)];
    assign b11_o = mem_q[b_idx(1, 1)];
    assign b12_o = mem_q[b_idx(1, 2)];
    assign b13_o = mem_q[b_idx(1, 3)];
    assign b21_o = mem_q[b_idx(2, 1)];
    assign b22_o = mem_q[b_idx(2, 2)];
    assign b23_o = mem_q[b_idx(2, 3)];
    assign b31_o = mem_q[b_idx(3, 1)];
    assign b32_o = mem_q[b_idx(3, 2)];
    assign b33_o = mem_q[b_idx(3, 3)];

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: a frame-level model checked every cycle plus
// directed scenarios with literal expectations. Honours LOADER_CHECKSUM_EN.
module tb_matrix_loader;

    localparam int unsigned TO = 8;
`ifdef LOADER_CHECKSUM_EN
    localparam int NB = 26;
    localparam int CK = 1;
`else
    localparam int NB = 25;
    localparam int CK = 0;
`endif

    logic       clk, reset, valid_i, done_capture_i;
    logic [7:0] data_i;
    logic       ready_o, run_valid_o, busy_o, err_o;
    logic [7:0] ab [25];

    matrix_loader #(.WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .a11_o(ab[0]),  .a12_o(ab[1]),  .a13_o(ab[2]),  .a14_o(ab[3]),
        .a21_o(ab[4]),  .a22_o(ab[5]),  .a23_o(ab[6]),  .a24_o(ab[7]),
        .a31_o(ab[8]),  .a32_o(ab[9]),  .a33_o(ab[10]), .a34_o(ab[11]),
        .a41_o(ab[12]), .a42_o(ab[13]), .a43_o(ab[14]), .a44_o(ab[15]),
        .b11_o(ab[16]), .b12_o(ab[17]), .b13_o(ab[18]),
        .b21_o(ab[19]), .b22_o(ab[20]), .b23_o(ab[21]),
        .b31_o(ab[22]), .b32_o(ab[23]), .b33_o(ab[24]),
        .run_valid_o(run_valid_o), .done_capture_i(done_capture_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int run_cnt = 0;
    int err_cnt = 0;
    int acc_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: phase 0=loading, 1=checksum verdict, 2=issue, 3=awaiting ack.
    int         m_phase = 0;
    int         m_waited = 0;
    bit         m_ok = 1'b0;
    bit         m_live = 1'b0;
    logic [7:0] m_regs [25];
    logic [7:0] m_q [$];

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_live   = 1'b1;
            m_phase  = 0;
            m_waited = 0;
            m_q.delete();
            foreach (m_regs[k]) m_regs[k] = 8'h00;
        end else if (m_live) begin
            case (m_phase)
                0: if (valid_i) begin
                    if (m_q.size() < 25) m_regs[m_q.size()] = data_i;
                    m_q.push_back(data_i);
                    if (m_q.size() == NB) begin
                        if (CK != 0) begin
                            int s = 0;
                            for (int k = 0; k < 25; k++) s += int'(m_q[k]);
                            m_ok = ((s % 256) == int'(m_q[NB-1]));
                            m_phase = 1;
                        end else begin
                            m_phase = 2;
                        end
                        m_q.delete();
                    end
                end
                1: m_phase = m_ok ? 2 : 0;
                2: begin
                    m_phase  = 3;
                    m_waited = 0;
                end
                default: begin
                    if (done_capture_i || (m_waited + 1 == int'(TO))) m_phase = 0;
                    else m_waited++;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            bit exp_err;
            exp_err = (m_phase == 3 && !done_capture_i && m_waited == int'(TO) - 1) ||
                      (m_phase == 1 && !m_ok);
            chk("ready", ready_o, m_phase == 0);
            chk("busy", busy_o, m_phase != 0);
            chk("run_valid", run_valid_o, m_phase == 2);
            chk("err", err_o, exp_err);
            for (int k = 0; k < 25; k++) chk($sformatf("reg%0d", k), ab[k], m_regs[k]);
            if (run_valid_o) run_cnt++;
            if (err_o) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        valid_i = 1'b1;
        data_i  = b;
        while (!ready_o && n < 200) begin
            tick();
            n++;
        end
        if (!ready_o) chk("ready_wait", ready_o, 1);
        tick();
        acc_cyc = cyc;
        valid_i = 1'b0;
    endtask

    function automatic logic [7:0] val(input int kind, input int k);
        case (kind)
            0:       return 8'(k + 1);
            1:       return 8'hAA;
            default: return 8'(100 + k);
        endcase
    endfunction

    task automatic send_range(input int kind, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send_byte(val(kind, k));
    endtask

    task automatic send_ck(input int kind);
        logic [7:0] s = 8'h00;
        for (int k = 0; k < 25; k++) s = s + val(kind, k);
        if (CK != 0) send_byte(s);
    endtask

    task automatic wait_run(output int at);
        int n = 0;
        while (!run_valid_o && n < 50) begin
            tick();
            n++;
        end
        at = cyc;
        chk("run_seen", run_valid_o, 1);
    endtask

    task automatic ack_after_run();
        tick();
        done_capture_i = 1'b1;
        tick();
        done_capture_i = 1'b0;
    endtask

    initial begin
        int r0, e0, run_at, n;
        reset = 1'b1;
        valid_i = 1'b0;
        data_i = 8'h00;
        done_capture_i = 1'b0;
        repeat (3) tick();
        chk("rst_a11", ab[0], 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_run", run_valid_o, 0);
        chk("rst_err", err_o, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", ready_o, 1);

        // Bytes 1..25 back-to-back, ack one cycle after the strobe.
        r0 = run_cnt;
        send_range(0, 0, 24);
        send_ck(0);
        wait_run(run_at);
        chk("t1_latency", run_at - acc_cyc, CK);
        ack_after_run();
        chk("t1_ready_back", ready_o, 1);
        chk("t1_run_count", run_cnt - r0, 1);
        chk("t1_a11", ab[0], 1);
        chk("t1_a44", ab[15], 16);
        chk("t1_b11", ab[16], 17);
        chk("t1_b33", ab[24], 25);

        // Long stall mid-frame.
        r0 = run_cnt;
        e0 = err_cnt;
        send_range(2, 0, 9);
        repeat (500) tick();
        chk("t2_stall_ready", ready_o, 1);
        send_range(2, 10, 24);
        send_ck(2);
        wait_run(run_at);
        ack_after_run();
        chk("t2_err_count", err_cnt - e0, 0);
        chk("t2_run_count", run_cnt - r0, 1);
        chk("t2_a11", ab[0], 100);
        chk("t2_b33", ab[24], 124);

        // No acknowledge: timeout abort.
        e0 = err_cnt;
        send_range(0, 0, 24);
        send_ck(0);
        wait_run(run_at);
        n = 0;
        while (!err_o && n < 40) begin
            tick();
            n++;
        end
        chk("t3_err_delay", cyc - run_at, TO);
        tick();
        chk("t3_ready_back", ready_o, 1);
        chk("t3_err_count", err_cnt - e0, 1);
        chk("t3_a11_kept", ab[0], 1);
        chk("t3_b33_kept", ab[24], 25);

        // Reset while awaiting acknowledge, then a frame of 0xAA.
        send_range(2, 0, 24);
        send_ck(2);
        wait_run(run_at);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("t4_rst_a11", ab[0], 0);
        chk("t4_rst_b33", ab[24], 0);
        chk("t4_rst_busy", busy_o, 0);
        chk("t4_rst_run", run_valid_o, 0);
        chk("t4_rst_err", err_o, 0);
        tick();
        reset = 1'b0;
        tick();
        r0 = run_cnt;
        send_range(1, 0, 24);
        send_ck(1);
        wait_run(run_at);
        ack_after_run();
        for (int k = 0; k < 25; k++) chk($sformatf("t4_aa%0d", k), ab[k], 8'hAA);
        chk("t4_run_count", run_cnt - r0, 1);

        // Stray acknowledges in LOAD and ISSUE are ignored.
        e0 = err_cnt;
        done_capture_i = 1'b1;
        repeat (2) tick();
        done_capture_i = 1'b0;
        send_range(0, 0, 24);
        send_ck(0);
        wait_run(run_at);
        done_capture_i = 1'b1;
        tick();
        done_capture_i = 1'b0;
        repeat (3) tick();
        chk("t5_still_busy", busy_o, 1);
        chk("t5_no_err", err_cnt - e0, 0);
        done_capture_i = 1'b1;
        tick();
        done_capture_i = 1'b0;
        chk("t5_ready_back", ready_o, 1);

`ifdef LOADER_CHECKSUM_EN
        r0 = run_cnt;
        send_range(0, 0, 24);
        send_byte(8'h45);
        wait_run(run_at);
        ack_after_run();
        chk("t6_good_run", run_cnt - r0, 1);
        r0 = run_cnt;
        e0 = err_cnt;
        send_range(0, 0, 24);
        send_byte(8'h00);
        n = 0;
        while (!err_o && n < 10) begin
            tick();
            n++;
        end
        chk("t6_bad_err_seen", err_o, 1);
        repeat (3) tick();
        chk("t6_bad_ready", ready_o, 1);
        chk("t6_bad_no_run", run_cnt - r0, 0);
        chk("t6_bad_err_count", err_cnt - e0, 1);
`endif

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter WAIT_TIMEOUT, default 255: maximum number of cycles spent in WAIT_DONE before aborting; legal range 1..65535.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data_i  input  8  stream byte, unsigned.
REQ-005 valid_i  input  1  data_i valid.
REQ-006 ready_o  output  1  loader accepts a byte; a transfer occurs when valid_i && ready_o at a rising edge.
REQ-007 a11_o..a44_o  output  8 each  16 input-matrix bytes, row-major, driving the capture memory's a-ports.
REQ-008 b11_o..b33_o  output  8 each  9 filter bytes, row-major, driving the capture memory's b-ports.
REQ-009 run_valid_o  output  1  capture strobe to the memory, one cycle wide.
REQ-010 done_capture_i  input  1  capture acknowledge from the memory.
REQ-011 busy_o  output  1  high in any state other than LOAD.
REQ-012 err_o  output  1  one-cycle pulse on abort (timeout, or checksum mismatch when enabled).

Function
REQ-013 The FSM SHALL have states LOAD, CHECK, ISSUE and WAIT_DONE. CHECK exists only when LOADER_CHECKSUM_EN is defined.
REQ-014 In LOAD, ready_o SHALL be 1. ready_o SHALL be 0 in every other state, and no byte is accepted outside LOAD.
REQ-015 A 5-bit byte counter SHALL start at 0. It increments by 1 per accepted byte. Byte k (0..15) writes the a-register in row-major order (0=a11, 3=a14, 4=a21, 15=a44). Byte k (16..24) writes the b-register in row-major order (16=b11, 24=b33).
REQ-016 Acceptance of byte 24 SHALL reset the counter to 0. Next state is ISSUE, or CHECK if the checksum is enabled.
REQ-017 run_valid_o SHALL be 1 exactly during the single ISSUE cycle. ISSUE always proceeds to WAIT_DONE.
REQ-018 Without the checksum, latency SHALL be: byte 24 accepted at edge N, run_valid_o high in the cycle after edge N.
REQ-019 a*_o and b*_o SHALL be registered and SHALL change only on accepted bytes. They are therefore stable from ISSUE through WAIT_DONE.
REQ-020 done_capture_i SHALL be sampled only in WAIT_DONE; it is ignored in all other states. done_capture_i=1 in WAIT_DONE SHALL return the FSM to LOAD at the next edge.
REQ-021 A 16-bit wait counter SHALL clear on entry to WAIT_DONE and increment each WAIT_DONE cycle.
REQ-022 If the wait counter reaches WAIT_TIMEOUT without done_capture_i, the loader SHALL pulse err_o for one cycle and return to LOAD.
REQ-023 If done_capture_i arrives in the same cycle the wait counter reaches WAIT_TIMEOUT, done SHALL win: no err_o, return to LOAD.
REQ-024 After an abort, the a/b registers SHALL retain their last values. The next frame overwrites them byte by byte.
REQ-025 valid_i low mid-frame SHALL stall without timeout. The counter holds its value indefinitely.

Reset
REQ-026 reset=1 at any edge, including mid-frame or in WAIT_DONE, SHALL force LOAD with byte counter 0, wait counter 0 and checksum accumulator 0.
REQ-027 During reset: every a*_o and b*_o SHALL be 8'h00, and run_valid_o, err_o and busy_o SHALL be 0. ready_o SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN, when defined, SHALL extend a frame to 26 bytes. Byte 25 is a checksum equal to the mod-256 sum of bytes 0..24, and it is not stored in any a/b register.
REQ-029 With LOADER_CHECKSUM_EN, the FSM enters CHECK for one cycle after byte 25. On a match it goes to ISSUE; on a mismatch it pulses err_o, issues no run_valid_o, and returns to LOAD.
REQ-030 Without LOADER_CHECKSUM_EN, the accumulator, the CHECK state and the checksum mismatch path SHALL NOT be synthesised, and frames are 25 bytes.

Structure
REQ-031 Shared package loader_pkg SHALL hold: the state enum; constants NUM_INPUT=16, NUM_FILTER=9 and FRAME_LEN=25; and the byte-index-to-port mapping constants.
REQ-032 The design SHALL be a single module with no sub-module. The a/b storage SHALL be a 25-entry register array indexed by the byte counter.

Verification
REQ-033 After reset, send bytes 1..25 back-to-back with done_capture_i asserted one cycle after run_valid_o. Required: a11_o=1, a44_o=16, b11_o=17, b33_o=25; exactly one run_valid_o pulse, one cycle after byte 25; ready_o back to 1 after done.
REQ-034 Send 10 bytes, hold valid_i low for 500 cycles, then send the remaining 15. Required: no err_o, and a single run_valid_o after the last byte.
REQ-035 With WAIT_TIMEOUT=8, complete a frame and never assert done_capture_i. Required: err_o pulses once, 8 cycles into WAIT_DONE; the FSM returns to LOAD with a/b outputs unchanged.
REQ-036 Assert reset while in WAIT_DONE, then send a new frame of all 8'hAA. Required: all outputs are 0 during reset; all a/b outputs equal 8'hAA afterwards; exactly one run_valid_o.
REQ-037 With LOADER_CHECKSUM_EN, send bytes 1..25 plus checksum 8'h45, then a second frame with checksum 8'h00. Required: the first frame produces run_valid_o; the second produces err_o and no run_valid_o.
REQ-038 Pulse done_capture_i during LOAD and ISSUE. Required: it is ignored, the FSM still enters WAIT_DONE, and the loader waits for a fresh done_capture_i.
